// File: rtl/watermark_noise_gen_if.sv
// rtl/watermark_noise_gen_if.sv - request/plane bundle for the watermark noise generator
// The region mask is carried only when WATERMARK_NOISE_REGION_EN is defined.
interface watermark_noise_gen_if #(
  parameter int WIDTH  = 56,
  parameter int HEIGHT = 24
);
  localparam int NPIX = WIDTH * HEIGHT;

  logic            start;
  logic [31:0]     seed;
  logic [8:0]      density;
`ifdef WATERMARK_NOISE_REGION_EN
  logic [NPIX-1:0] region;
`endif
  logic            busy;
  logic            done;
  logic            valid;
  logic [NPIX-1:0] pixwatermark;

`ifdef WATERMARK_NOISE_REGION_EN
  modport master (output start, seed, density, region,
                  input  busy, done, valid, pixwatermark);
  modport slave  (input  start, seed, density, region,
                  output busy, done, valid, pixwatermark);
`else
  modport master (output start, seed, density,
                  input  busy, done, valid, pixwatermark);
  modport slave  (input  start, seed, density,
                  output busy, done, valid, pixwatermark);
`endif
endinterface

// File: rtl/watermark_noise_gen.sv
// rtl/watermark_noise_gen.sv - LFSR noise plane generator, four pixels per cycle
// Optional WATERMARK_NOISE_REGION_EN masks each pixel with the region input.
module watermark_noise_gen #(
  parameter int WIDTH  = 56,
  parameter int HEIGHT = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  watermark_noise_gen_if.slave bus
);
  localparam int NPIX = WIDTH * HEIGHT;
  localparam int N    = NPIX / 4;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [31:0]   TAPS = 32'h80200003;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [31:0]     lfsr_q, lfsr_d;
  logic [8:0]      dens_q, dens_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NPIX-1:0] pix_q, pix_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;
  logic [3:0]      chunk;
  logic [CW+1:0]   base;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (bus.start) state_d = RUN;
      RUN:        if (cnt_q == LAST) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy         = (state_q == RUN);
    bus.done         = done_q;
    bus.valid        = valid_q;
    bus.pixwatermark = pix_q;
  end

  // Byte j of the current LFSR state decides pixel j of the chunk.
  always_comb begin
    lfsr_d  = lfsr_q;
    dens_d  = dens_q;
    cnt_d   = cnt_q;
    pix_d   = pix_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    chunk   = '0;
    base    = {cnt_q, 2'b00};
    if (state_q != RUN && bus.start) begin
      lfsr_d  = (bus.seed == 32'd0) ? 32'd1 : bus.seed;
      dens_d  = bus.density;
      cnt_d   = '0;
      pix_d   = '0;
      valid_d = 1'b0;
    end else if (state_q == RUN) begin
      for (int j = 0; j < 4; j++) begin
        chunk[j] = ({1'b0, lfsr_q[8*j +: 8]} < dens_q);
      end
`ifdef WATERMARK_NOISE_REGION_EN
      chunk = chunk & bus.region[base +: 4];
`endif
      pix_d[base +: 4] = chunk;
      lfsr_d = lfsr_step(lfsr_q);
      cnt_d  = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        valid_d = 1'b1;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q  <= 32'd1;
      dens_q  <= '0;
      cnt_q   <= '0;
      pix_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      dens_q  <= dens_d;
      cnt_q   <= cnt_d;
      pix_q   <= pix_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_watermark_noise_gen.sv
// tb/tb_watermark_noise_gen.sv - randomized plane checks against a behavioural noise model
module tb_watermark_noise_gen;
  localparam int W    = 56;
  localparam int H    = 24;
  localparam int NPIX = W * H;
  localparam int N    = NPIX / 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  watermark_noise_gen_if #(.WIDTH(W), .HEIGHT(H)) bus ();
  watermark_noise_gen #(.WIDTH(W), .HEIGHT(H)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  logic [NPIX-1:0] rgn;
  logic [NPIX-1:0] exp_plane;
  logic [NPIX-1:0] saved;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NPIX-1:0] ref_plane(input logic [31:0] sd, input int dn,
                                                input logic [NPIX-1:0] rg);
    logic [NPIX-1:0] p;
    logic [31:0] s;
    p = '0;
    s = (sd == 32'd0) ? 32'd1 : sd;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < 4; j++) begin
        int v;
        v = int'((s >> (8 * j)) & 32'hff);
        p[4*k+j] = (v < dn) && rg[4*k+j];
      end
      s = s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
    end
    return p;
  endfunction

  task automatic check_plane(input string tag, input logic [NPIX-1:0] e);
    for (int y = 0; y < H; y++) begin
      chk($sformatf("%s_row%0d", tag, y), 64'(bus.pixwatermark[y*W +: W]), 64'(e[y*W +: W]));
    end
  endtask

  // Starts at a negedge, returns at the negedge where done is seen.
  task automatic run_plane(input logic [31:0] sd, input int dn, input bit mid_start,
                           input string tag);
    int edges;
    exp_plane = ref_plane(sd, dn, rgn);
`ifdef WATERMARK_NOISE_REGION_EN
    bus.region = rgn;
`endif
    bus.start   = 1'b1;
    bus.seed    = sd;
    bus.density = 9'(dn);
    @(negedge clk);
    edges = 1;
    bus.start   = 1'b0;
    bus.seed    = $urandom;
    bus.density = 9'($urandom_range(0, 256));
    chk({tag, "_busy_start"}, 64'(bus.busy), 64'd1);
    chk({tag, "_valid_start"}, 64'(bus.valid), 64'd0);
    while (!bus.done && edges < N + 20) begin
      bus.start = mid_start && (edges == N / 2);
      @(negedge clk);
      edges++;
    end
    bus.start = 1'b0;
    chk({tag, "_latency"}, 64'(edges), 64'(N + 1));
    chk({tag, "_valid_end"}, 64'(bus.valid), 64'd1);
    chk({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
    check_plane(tag, exp_plane);
  endtask

  initial begin
    logic [31:0] sd;
    rgn         = '1;
    bus.start   = 1'b0;
    bus.seed    = '0;
    bus.density = '0;
`ifdef WATERMARK_NOISE_REGION_EN
    bus.region  = rgn;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_valid", 64'(bus.valid), 64'd0);
    check_plane("rst_plane", '0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_busy", 64'(bus.busy), 64'd0);
    chk("idle_valid", 64'(bus.valid), 64'd0);
    chk("idle_done", 64'(bus.done), 64'd0);
    chk("idle_plane_row0", 64'(bus.pixwatermark[W-1:0]), 64'd0);

    run_plane(32'd1, 1, 1'b0, "s1d1");
    chk("s1d1_px0to7", 64'(bus.pixwatermark[7:0]), 64'h2e);
    @(negedge clk);
    chk("s1d1_done_pulse", 64'(bus.done), 64'd0);
    chk("s1d1_valid_hold", 64'(bus.valid), 64'd1);
    check_plane("s1d1_hold", exp_plane);

    run_plane($urandom, 0, 1'b0, "d0");
    check_plane("d0_zero", '0);
    @(negedge clk);
    run_plane($urandom, 256, 1'b0, "d256");
    check_plane("d256_ones", rgn);
    @(negedge clk);

    run_plane(32'd0, 100, 1'b0, "seed0");
    saved = bus.pixwatermark;
    @(negedge clk);
    run_plane(32'd1, 100, 1'b0, "seed1");
    check_plane("seed_equiv", saved);
    @(negedge clk);

    for (int r = 0; r < 5; r++) begin
`ifdef WATERMARK_NOISE_REGION_EN
      for (int i = 0; i < NPIX; i += 32) rgn[i +: 32] = $urandom;
`endif
      run_plane($urandom, $urandom_range(0, 256), 1'b0, $sformatf("rnd%0d", r));
      @(negedge clk);
    end
    rgn = '1;

    run_plane($urandom, $urandom_range(1, 255), 1'b1, "midstart");
    @(negedge clk);

    run_plane($urandom, $urandom_range(1, 255), 1'b0, "b2b_a");
    run_plane($urandom, $urandom_range(1, 255), 1'b0, "b2b_b");
    @(negedge clk);

    sd = $urandom;
    bus.start   = 1'b1;
    bus.seed    = sd;
    bus.density = 9'd200;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_done", 64'(bus.done), 64'd0);
    chk("arst_valid", 64'(bus.valid), 64'd0);
    check_plane("arst_plane", '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef WATERMARK_NOISE_REGION_EN
    rgn = '0;
    for (int y = H / 2; y < H; y++) rgn[y*W +: W] = '1;
    run_plane($urandom, 256, 1'b0, "region");
    check_plane("region_exact", rgn);
    @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/watermark_noise_gen.md
# watermark_noise_gen

Sequential generator for the pseudo-random noise bitmap consumed as the `pixwatermark` operand of the garbler-side watermark OR-merge stage. On a start request it fills a WIDTH×HEIGHT bit plane from a seeded 32-bit LFSR, four pixels per cycle, with a programmable pixel density. It holds the finished plane stable until the next request. It sits directly upstream of the watermark merge, in parallel with the segment renderer that produces `pixsegments`.

## Interface
- WIDTH, 56: display width in pixels.
- HEIGHT, 24: display height in pixels. WIDTH*HEIGHT must be a multiple of 4.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to generate a new plane. Honoured only in IDLE or DONE.
- seed  in  32  LFSR seed, sampled with start. A value of 0 is replaced by 32'h00000001.
- density  in  9  threshold, sampled with start. Range 0..256; 0 gives all pixels off, 256 gives all pixels on.
- region  in  WIDTH*HEIGHT  noise-enable mask. Present only with WATERMARK_NOISE_REGION_EN.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on the cycle the plane completes.
- valid  out  1  level, high while pixwatermark holds a complete plane.
- pixwatermark  out  WIDTH*HEIGHT  noise plane, registered. Bit index i = y*WIDTH + x.

## Operation
- N = WIDTH*HEIGHT/4 chunks. Chunk k covers pixel bits 4k..4k+3.
- FSM states:
  - IDLE (reset state).
  - RUN.
  - DONE.
- IDLE/DONE + start: perform all of the following, then go to RUN.
  - lfsr ← seed (0→1).
  - dens ← density.
  - cnt ← 0.
  - pixwatermark ← 0.
  - valid ← 0.
- RUN, every cycle:
  - Pixel 4·cnt+j (j=0..3) ← (lfsr[8j+7:8j] < dens). Compare unsigned at 9 bits.
  - Then step the lfsr and set cnt ← cnt+1.
- LFSR step (Galois, right shift, mask 32'h80200003): b = lfsr[0]; lfsr ← lfsr>>1; if b, lfsr ← lfsr ^ 32'h80200003. The state is never 0.
- RUN exit: on the cycle that writes chunk N-1, go to DONE, valid ← 1, done ← 1 for exactly that one cycle.
- start in RUN is ignored: no restart, no queueing.
- start in DONE restarts. valid drops on the same edge and the plane is cleared.
- seed, density and region may change freely outside the start edge. region is sampled per chunk during RUN and must be held stable by the caller.
- cnt width = clog2(N). No wrap-around occurs, because RUN exits at N-1.

## Timing
- Reset values: state IDLE; busy=0, done=0, valid=0; pixwatermark=0; lfsr=1; cnt=0.
- start sampled at edge E0: busy=1 after E0. Chunk k is written at edge E0+1+k. valid=1 and done=1 after edge E0+N; busy=0 after that edge.
- Latency from start to valid: N+1 cycles.
- Back-to-back planes: start may be asserted in the same cycle that done is high. The next RUN then begins one edge later.
- rst_n low mid-RUN: all registers return to reset values immediately (asynchronous). No partial plane stays visible.
- Throughput: 4 pixels per cycle. Each chunk consumes exactly one LFSR step.

## Configuration
- WATERMARK_NOISE_REGION_EN defined:
  - The region port exists.
  - Pixel i is written as noise_i & region[i].
- WATERMARK_NOISE_REGION_EN undefined:
  - No region port.
  - Noise is written unmasked.
  - All timing is identical in both builds.

## Test plan
- Reset: hold rst_n low, then release. Expect valid=0, busy=0, done=0, pixwatermark all 0; start never asserted → outputs stay unchanged.
- Seed 1, density 1: chunk 0 uses state 32'h00000001 → pixels 0..3 = 0,1,1,1. Chunk 1 uses state 32'h80200003 → pixels 4..7 = 0,1,0,0. done is high exactly N+1 cycles after start.
- Density extremes: density 0 → plane all 0. density 256 → plane all 1 (all-1 ANDed with region if WATERMARK_NOISE_REGION_EN is defined). Both cases take the same latency.
- Seed 0 vs seed 1 with equal density: the two planes are bit-identical.
- Robustness:
  - start pulsed mid-RUN → ignored; the plane matches the single-run golden model.
  - start in the done cycle → valid falls, new run completes N+1 cycles later.
  - rst_n pulsed mid-RUN → all outputs 0 asynchronously.
- WATERMARK_NOISE_REGION_EN build: region = lower half rows only, density 256 → pixwatermark equals region exactly.
